sawtooth_fx_iter: RTL and testbench

//   Fixed-point, parametrised successor of the FP sawtooth map. Computes the fold count
//   L = floor((x+eps)/(2*eps)) and y = x - 2*eps*L, with y in [-eps, eps), using an

---
 rtl/sawtooth_fx_iter.sv | 191 +++++++++++++++++++
 tb/tb_sawtooth_fx_iter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sawtooth_fx_iter.sv
// Fixed-point sawtooth fold: L = floor((x+eps)/(2*eps)), y = x - 2*eps*L in [-eps, eps),
// computed with an iterative restoring divider. Optional fold mode negates y when L is odd.
// Build option: define SAWTOOTH_EARLY_OUT_EN to bypass the divider when -eps <= x < eps.
module sawtooth_fx_iter #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned FRAC_BITS = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sawtooth_tvalid,
  output logic             sawtooth_tready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] epsilon,
  input  logic             fold_en,
  output logic             sawtooth_valid,
  input  logic             sawtooth_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH:0]   l_out,
  output logic             eps_err
);

  localparam int unsigned W1    = WIDTH + 1;
  localparam int unsigned W2    = WIDTH + 2;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  // The Q format only sets the interpretation of the operands; the datapath is format-agnostic.
  if (FRAC_BITS >= WIDTH) begin : g_frac_bits_out_of_range
  end

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] eps_q, eps_d;
  logic             fold_q, fold_d;
  logic             neg_q, neg_d;
  logic [W1-1:0]    dsr_q, dsr_d;
  logic [W1-1:0]    rem_q, rem_d;
  logic [W1-1:0]    quo_q, quo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tready_q, tready_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH:0]   l_q, l_d;
  logic             err_q, err_d;

  // Operand preparation: n = x + eps and d = 2*eps, both WIDTH+1 bits so x = min is safe.
  logic [W1-1:0] n_in, n_abs, d_in;
  logic          eps_bad;
  assign n_in    = {x[WIDTH-1], x} + {epsilon[WIDTH-1], epsilon};
  assign n_abs   = n_in[W1-1] ? (~n_in + W1'(1)) : n_in;
  assign d_in    = {epsilon, 1'b0};
  assign eps_bad = (epsilon == '0) || epsilon[WIDTH-1];

`ifdef SAWTOOTH_EARLY_OUT_EN
  logic in_range;
  assign in_range = ($signed(x) >= -$signed(epsilon)) && ($signed(x) < $signed(epsilon));
`endif

  // One restoring-division step: shift in the next dividend bit, subtract d if it fits.
  logic [W2-1:0] rem_sh, rem_sub;
  logic          take;
  assign rem_sh  = {rem_q, quo_q[W1-1]};
  assign rem_sub = rem_sh - {1'b0, dsr_q};
  assign take    = ~rem_sub[W2-1];

  // Floor correction for negative n, then y = r - eps with optional fold.
  logic          adj;
  logic [W1-1:0] q_fix, r_fix, l_fix;
  logic [WIDTH-1:0] y_raw, y_fix;
  assign adj   = neg_q && (rem_q != '0);
  assign q_fix = adj ? (quo_q + W1'(1)) : quo_q;
  assign r_fix = adj ? (dsr_q - rem_q) : rem_q;
  assign l_fix = neg_q ? (~q_fix + W1'(1)) : q_fix;
  assign y_raw = WIDTH'(r_fix - {1'b0, eps_q});
  assign y_fix = (fold_q && l_fix[0]) ? (~y_raw + WIDTH'(1)) : y_raw;

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    eps_d    = eps_q;
    fold_d   = fold_q;
    neg_d    = neg_q;
    dsr_d    = dsr_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    result_d = result_q;
    l_d      = l_q;
    err_d    = err_q;
    tready_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sawtooth_tvalid && tready_q) begin
          eps_d  = epsilon;
          fold_d = fold_en;
          neg_d  = n_in[W1-1];
          dsr_d  = d_in;
          // |n| < 2^WIDTH and d >= 2, so the first quotient bit is always 0: resolve it
          // here and leave the remaining WIDTH bits to DIV.
          rem_d  = W1'(n_abs[W1-1]);
          quo_d  = {n_abs[W1-2:0], 1'b0};
          cnt_d  = CNT_W'(1);
          if (eps_bad) begin
            state_d  = S_DONE;
            valid_d  = 1'b1;
            result_d = '0;
            l_d      = '0;
            err_d    = 1'b1;
          end
`ifdef SAWTOOTH_EARLY_OUT_EN
          else if (in_range) begin
            state_d  = S_DONE;
            valid_d  = 1'b1;
            result_d = x;
            l_d      = '0;
            err_d    = 1'b0;
          end
`endif
          else begin
            state_d = S_DIV;
          end
        end
      end
      S_DIV: begin
        rem_d = take ? rem_sub[W1-1:0] : rem_sh[W1-1:0];
        quo_d = {quo_q[W1-2:0], take};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        result_d = y_fix;
        l_d      = l_fix;
        err_d    = 1'b0;
        valid_d  = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (sawtooth_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    tready_d = (state_d == S_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      eps_q    <= '0;
      fold_q   <= 1'b0;
      neg_q    <= 1'b0;
      dsr_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      tready_q <= 1'b1;
      valid_q  <= 1'b0;
      result_q <= '0;
      l_q      <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      eps_q    <= eps_d;
      fold_q   <= fold_d;
      neg_q    <= neg_d;
      dsr_q    <= dsr_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      tready_q <= tready_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      l_q      <= l_d;
      err_q    <= err_d;
    end
  end

  assign sawtooth_tready = tready_q;
  assign sawtooth_valid  = valid_q;
  assign result          = result_q;
  assign l_out           = l_q;
  assign eps_err         = err_q;

endmodule

// File: tb/tb_sawtooth_fx_iter.sv
// Self-checking bench for sawtooth_fx_iter (WIDTH=32, FRAC_BITS=16).
// Honours SAWTOOTH_EARLY_OUT_EN for the expected latency of in-range operands.
module tb_sawtooth_fx_iter;

  logic        clk;
  logic        reset_n;
  logic        sawtooth_tvalid;
  logic        sawtooth_tready;
  logic [31:0] x;
  logic [31:0] epsilon;
  logic        fold_en;
  logic        sawtooth_valid;
  logic        sawtooth_ready;
  logic [31:0] result;
  logic [32:0] l_out;
  logic        eps_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_res;
  logic [32:0] exp_l;
  logic        exp_err;

  sawtooth_fx_iter #(.WIDTH(32), .FRAC_BITS(16)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .sawtooth_tvalid (sawtooth_tvalid),
    .sawtooth_tready (sawtooth_tready),
    .x               (x),
    .epsilon         (epsilon),
    .fold_en         (fold_en),
    .sawtooth_valid  (sawtooth_valid),
    .sawtooth_ready  (sawtooth_ready),
    .result          (result),
    .l_out           (l_out),
    .eps_err         (eps_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Golden model: floor division on wide integers, straight from the defining equations.
  task automatic model(input logic [31:0] xi, input logic [31:0] ei, input logic fi,
                       output logic [31:0] r, output logic [32:0] l, output logic e);
    longint xv, ev, n, d, q, y;
    if (ei == 32'd0 || ei[31]) begin
      r = '0; l = '0; e = 1'b1;
      return;
    end
    xv = longint'($signed(xi));
    ev = longint'(ei);
    n  = xv + ev;
    d  = 2 * ev;
    q  = n / d;
    if ((n % d != 0) && (n < 0)) q = q - 1;
    y  = xv - d * q;
    if (fi && q[0]) y = -y;
    r = y[31:0];
    l = q[32:0];
    e = 1'b0;
  endtask

  function automatic bit short_path(input logic [31:0] xi, input logic [31:0] ei);
    if (ei == 32'd0 || ei[31]) return 1'b1;
`ifdef SAWTOOTH_EARLY_OUT_EN
    if (($signed(xi) >= -$signed(ei)) && ($signed(xi) < $signed(ei))) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // Continuous compare against the model whenever a result is presented.
  always @(negedge clk) begin
    if (reset_n && sawtooth_valid) begin
      check("cmp_result", 64'(result), 64'(exp_res));
      check("cmp_l_out", 64'(l_out), 64'(exp_l));
      check("cmp_eps_err", 64'(eps_err), 64'(exp_err));
      check("cmp_tready_busy", 64'(sawtooth_tready), 64'd0);
    end
  end

  // One transaction: accept, bounded wait for valid, latency check, optional literal
  // check, optional backpressure, then handshake. Garbage is kept on the inputs while busy.
  task automatic run_op(input string tag, input logic [31:0] xi, input logic [31:0] ei,
                        input logic fi, input int hold, input bit lit_en,
                        input logic [31:0] lit_res, input logic [32:0] lit_l,
                        input logic lit_err);
    int g;
    int lat;
    int exp_lat;
    model(xi, ei, fi, exp_res, exp_l, exp_err);
    exp_lat = short_path(xi, ei) ? 1 : 34;
    g = 0;
    while (!sawtooth_tready && g < 100) begin
      @(posedge clk); #1; g++;
    end
    check({tag, "_tready_idle"}, 64'(sawtooth_tready), 64'd1);
    x = xi; epsilon = ei; fold_en = fi; sawtooth_tvalid = 1'b1;
    @(posedge clk); #1;
    x = $urandom; epsilon = $urandom; fold_en = 1'($urandom);
    lat = 1;
    while (!sawtooth_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    if (lit_en) begin
      check({tag, "_lit_result"}, 64'(result), 64'(lit_res));
      check({tag, "_lit_l_out"}, 64'(l_out), 64'(lit_l));
      check({tag, "_lit_eps_err"}, 64'(eps_err), 64'(lit_err));
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
    end
    if (hold > 0) begin
      check({tag, "_valid_held"}, 64'(sawtooth_valid), 64'd1);
      if (lit_en) check({tag, "_held_result"}, 64'(result), 64'(lit_res));
    end
    sawtooth_ready = 1'b1;
    @(posedge clk); #1;
    sawtooth_ready  = 1'b0;
    sawtooth_tvalid = 1'b0;
    check({tag, "_valid_drop"}, 64'(sawtooth_valid), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rx, re;
    reset_n = 1'b0; sawtooth_tvalid = 1'b0; sawtooth_ready = 1'b0;
    x = '0; epsilon = '0; fold_en = 1'b0;
    exp_res = '0; exp_l = '0; exp_err = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    check("rst_valid", 64'(sawtooth_valid), 64'd0);
    check("rst_tready", 64'(sawtooth_tready), 64'd1);
    check("rst_result", 64'(result), 64'd0);
    check("rst_l_out", 64'(l_out), 64'd0);
    check("rst_eps_err", 64'(eps_err), 64'd0);

    // Directed vectors with hand-computed results.
    run_op("p2p5",      32'h0002_8000, 32'h0001_0000, 1'b0, 0, 1'b1, 32'h0000_8000, 33'd1, 1'b0);
    run_op("p2p5_fold", 32'h0002_8000, 32'h0001_0000, 1'b1, 0, 1'b1, 32'hFFFF_8000, 33'd1, 1'b0);
    run_op("m2p5",      32'hFFFD_8000, 32'h0001_0000, 1'b0, 0, 1'b1, 32'hFFFF_8000, 33'h1_FFFF_FFFF, 1'b0);
    run_op("m2p5_fold", 32'hFFFD_8000, 32'h0001_0000, 1'b1, 0, 1'b1, 32'h0000_8000, 33'h1_FFFF_FFFF, 1'b0);
    run_op("edge_1eps", 32'h0001_0000, 32'h0001_0000, 1'b0, 10, 1'b1, 32'hFFFF_0000, 33'd1, 1'b0);
    run_op("edge_fold", 32'h0001_0000, 32'h0001_0000, 1'b1, 0, 1'b1, 32'h0001_0000, 33'd1, 1'b0);
    run_op("eps_zero",  32'h0002_8000, 32'h0000_0000, 1'b0, 0, 1'b1, 32'h0, 33'd0, 1'b1);
    run_op("eps_neg",   32'h0002_8000, 32'h8000_0000, 1'b1, 3, 1'b1, 32'h0, 33'd0, 1'b1);
    run_op("in_range",  32'h0000_4000, 32'h0001_0000, 1'b0, 0, 1'b1, 32'h0000_4000, 33'd0, 1'b0);
    run_op("x_min",     32'h8000_0000, 32'h0001_0000, 1'b0, 0, 1'b1, 32'h0, 33'h1_FFFF_C000, 1'b0);
    run_op("x_min_e1",  32'h8000_0000, 32'h0000_0001, 1'b1, 0, 1'b1, 32'h0, 33'h1_C000_0000, 1'b0);
    run_op("x_max",     32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 0, 1'b1, 32'h8000_0001, 33'd1, 1'b0);

    // Reset in the middle of a division discards it.
    x = 32'h0002_8000; epsilon = 32'h0001_0000; fold_en = 1'b0; sawtooth_tvalid = 1'b1;
    @(posedge clk); #1;
    sawtooth_tvalid = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_valid", 64'(sawtooth_valid), 64'd0);
    check("midrst_result", 64'(result), 64'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_tready", 64'(sawtooth_tready), 64'd1);
    check("midrst_valid_after", 64'(sawtooth_valid), 64'd0);
    run_op("post_rst",  32'hFFFD_8000, 32'h0001_0000, 1'b1, 0, 1'b1, 32'h0000_8000, 33'h1_FFFF_FFFF, 1'b0);

    // Random sweep against the model.
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0: re = $urandom_range(1, 32'h0000_FFFF);
        1: re = $urandom_range(32'h0000_8000, 32'h0004_0000);
        2: re = $urandom_range(1, 32'h7FFF_FFFF);
        default: re = ($urandom_range(0, 1) == 0) ? 32'h0 : (32'h8000_0000 | $urandom);
      endcase
      rx = $urandom;
      run_op("rand", rx, re, 1'($urandom), int'($urandom_range(0, 2)), 1'b0, 32'h0, 33'd0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
